// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants for the operand-forwarding unit.
//   STOP / NO_STOP    : encoding of one pipeline stall-vector bit
//   ID_IDX_DEF/EX_IDX_DEF : default stall bit positions of ID and EX
//   ZERO_REG          : hard-wired zero register, never forwarded
package fwd_pkg;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam int   ID_IDX_DEF = 2;
  localparam int   EX_IDX_DEF = 3;
  localparam int   ZERO_REG   = 0;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: compares one source read port against every producer stage.
// Ports:
//   re, raddr           : read enable and register address of this port
//   stg_we/waddr/wdata  : producer write enable, address, data per stage
//   stg_is_load         : producer data is not final yet (load in flight)
//   sel                 : some stage matches this port
//   data                : data of the winning (youngest matching) stage, else 0
//   load_hazard         : winning stage is a load still inside the load shadow
module fwd_match
  import fwd_pkg::*;
#(
  parameter int NUM_STG  = 2,
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  input  logic [NUM_STG-1:0]    stg_we,
  input  logic [NUM_STG*AW-1:0] stg_waddr,
  input  logic [NUM_STG*DW-1:0] stg_wdata,
  input  logic [NUM_STG-1:0]    stg_is_load,
  output logic                  sel,
  output logic [DW-1:0]         data,
  output logic                  load_hazard
);

  logic [NUM_STG-1:0] hit;

  always_comb begin
    for (int s = 0; s < NUM_STG; s++) begin
      hit[s] = re & stg_we[s] & (stg_waddr[s*AW +: AW] == raddr) &
               (raddr != AW'(ZERO_REG));
    end
  end

  // Walk from oldest to youngest so the youngest match is written last
  // and wins; the hazard flag follows the winner only, so an older
  // non-load match cannot hide a younger load.
  always_comb begin
    sel         = 1'b0;
    data        = '0;
    load_hazard = 1'b0;
    for (int s = NUM_STG-1; s >= 0; s--) begin
      if (hit[s]) begin
        sel         = 1'b1;
        data        = stg_wdata[s*DW +: DW];
        load_hazard = (s < LOAD_LAT) && stg_is_load[s];
      end
    end
  end

endmodule

// File: rtl/fwd_unit_n.sv
// fwd_unit_n: parametrised operand-forwarding unit beside ID.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   stall               : pipeline stall vector (1 = stop)
//   src_re/src_raddr    : read enable and address per source port
//   stg_*               : producer write enable/address/data/is_load per stage
//   fwd_sel/fwd_data    : registered bypass select and data per source port
//   stall_for_load      : combinational load-use hazard request
//   load_stall_cnt      : saturating count of cycles with stall_for_load high
//   cnt_clr             : synchronous clear of load_stall_cnt
module fwd_unit_n
  import fwd_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 2,
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int STALL_W  = 6,
  parameter int ID_IDX   = ID_IDX_DEF,
  parameter int EX_IDX   = EX_IDX_DEF,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic [NUM_SRC-1:0]    src_re,
  input  logic [NUM_SRC*AW-1:0] src_raddr,
  input  logic [NUM_STG-1:0]    stg_we,
  input  logic [NUM_STG*AW-1:0] stg_waddr,
  input  logic [NUM_STG*DW-1:0] stg_wdata,
  input  logic [NUM_STG-1:0]    stg_is_load,
  output logic [NUM_SRC-1:0]    fwd_sel,
  output logic [NUM_SRC*DW-1:0] fwd_data,
  output logic                  stall_for_load,
  output logic [CNT_W-1:0]      load_stall_cnt,
  input  logic                  cnt_clr
);

  logic [NUM_SRC-1:0]    sel_nxt;
  logic [NUM_SRC*DW-1:0] data_nxt;
  logic [NUM_SRC-1:0]    haz;
  logic                  bubble;
  logic                  hold;
  logic                  unused_stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_match #(
      .NUM_STG  (NUM_STG),
      .DW       (DW),
      .AW       (AW),
      .LOAD_LAT (LOAD_LAT)
    ) u_match (
      .re          (src_re[i]),
      .raddr       (src_raddr[i*AW +: AW]),
      .stg_we      (stg_we),
      .stg_waddr   (stg_waddr),
      .stg_wdata   (stg_wdata),
      .stg_is_load (stg_is_load),
      .sel         (sel_nxt[i]),
      .data        (data_nxt[i*DW +: DW]),
      .load_hazard (haz[i])
    );
  end

  assign stall_for_load = |haz;

  // Only the ID and EX bits matter here; the rest of the vector is ignored.
  assign unused_stall = ^stall;
  assign bubble = (stall[ID_IDX] == STOP) && (stall[EX_IDX] == NO_STOP);
  assign hold   = (stall[ID_IDX] == STOP) && (stall[EX_IDX] == STOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_sel  <= '0;
      fwd_data <= '0;
    end else if (bubble) begin
      fwd_sel  <= '0;
      fwd_data <= '0;
    end else if (!hold) begin
      fwd_sel  <= sel_nxt;
      fwd_data <= data_nxt;
    end
  end

  // Counts every hazard cycle, stalled or not; saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_stall_cnt <= '0;
    end else if (cnt_clr) begin
      load_stall_cnt <= '0;
    end else if (stall_for_load && (load_stall_cnt != {CNT_W{1'b1}})) begin
      load_stall_cnt <= load_stall_cnt + CNT_W'(1);
    end
  end

endmodule
